// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, control-strobe bit positions, step codes and instruction classes
package alu_seq_pkg;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110, OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000, OP_SHL = 5'b01001, OP_ROR = 5'b01010, OP_ROL = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110, OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000, OP_NEG = 5'b10001, OP_NOT = 5'b10010, OP_BR = 5'b10011;
  localparam logic [4:0] OP_JR = 5'b10100, OP_JAL = 5'b10101, OP_IN = 5'b10110, OP_OUT = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP = 5'b11010, OP_HALT = 5'b11011;
  localparam int PCOUT = 0, PCIN = 1, INCPC = 2, MARIN = 3, MDRIN = 4, MDROUT = 5, IRIN = 6, READ = 7;
  localparam int WRITE = 8, YIN = 9, ZIN = 10, ZHI_OUT = 11, ZLO_OUT = 12, HIIN = 13, LOIN = 14, HIOUT = 15;
  localparam int LOOUT = 16, GRA = 17, GRB = 18, GRC = 19, RIN = 20, ROUT = 21, BAOUT = 22, COUT = 23;
  localparam int CONIN = 24, INPORTOUT = 25, OUTPORTIN = 26, BRANCH_FLAG = 27;
  // 24 datapath strobes plus four upper control bits
  localparam int CTRL_BITS = 28;
  localparam logic [CTRL_BITS-1:0] M_PCOUT = CTRL_BITS'(1) << PCOUT, M_PCIN = CTRL_BITS'(1) << PCIN;
  localparam logic [CTRL_BITS-1:0] M_INCPC = CTRL_BITS'(1) << INCPC, M_MARIN = CTRL_BITS'(1) << MARIN;
  localparam logic [CTRL_BITS-1:0] M_MDRIN = CTRL_BITS'(1) << MDRIN, M_MDROUT = CTRL_BITS'(1) << MDROUT;
  localparam logic [CTRL_BITS-1:0] M_IRIN = CTRL_BITS'(1) << IRIN, M_READ = CTRL_BITS'(1) << READ;
  localparam logic [CTRL_BITS-1:0] M_WRITE = CTRL_BITS'(1) << WRITE, M_YIN = CTRL_BITS'(1) << YIN;
  localparam logic [CTRL_BITS-1:0] M_ZIN = CTRL_BITS'(1) << ZIN, M_ZHI = CTRL_BITS'(1) << ZHI_OUT;
  localparam logic [CTRL_BITS-1:0] M_ZLO = CTRL_BITS'(1) << ZLO_OUT, M_HIIN = CTRL_BITS'(1) << HIIN;
  localparam logic [CTRL_BITS-1:0] M_LOIN = CTRL_BITS'(1) << LOIN, M_HIOUT = CTRL_BITS'(1) << HIOUT;
  localparam logic [CTRL_BITS-1:0] M_LOOUT = CTRL_BITS'(1) << LOOUT, M_GRA = CTRL_BITS'(1) << GRA;
  localparam logic [CTRL_BITS-1:0] M_GRB = CTRL_BITS'(1) << GRB, M_GRC = CTRL_BITS'(1) << GRC;
  localparam logic [CTRL_BITS-1:0] M_RIN = CTRL_BITS'(1) << RIN, M_ROUT = CTRL_BITS'(1) << ROUT;
  localparam logic [CTRL_BITS-1:0] M_BAOUT = CTRL_BITS'(1) << BAOUT, M_COUT = CTRL_BITS'(1) << COUT;
  localparam logic [CTRL_BITS-1:0] M_CONIN = CTRL_BITS'(1) << CONIN, M_INPORT = CTRL_BITS'(1) << INPORTOUT;
  localparam logic [CTRL_BITS-1:0] M_OUTPORT = CTRL_BITS'(1) << OUTPORTIN, M_BRF = CTRL_BITS'(1) << BRANCH_FLAG;
  // state encoding doubles as the step code; idle reports T0
  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_IDLE, S_FAULT = 4'hE, S_HALT = 4'hF
  } state_e;
  typedef enum logic [3:0] {
    C_R, C_IMM, C_MD, C_UN, C_LD, C_LDI, C_ST, C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_e;
endpackage

// File: rtl/alu_op_sequencer_decode.sv
// seq_decode: maps an opcode to its instruction class and final execute step
module seq_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0] opc,
  output cls_e       cls,
  output logic [3:0] last
);
  always_comb begin
    cls = C_NOP;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = C_R;
      OP_ADDI, OP_ANDI, OP_ORI: cls = C_IMM;
      OP_MUL, OP_DIV: cls = C_MD;
      OP_NEG, OP_NOT: cls = C_UN;
      OP_LD: cls = C_LD;
      OP_LDI: cls = C_LDI;
      OP_ST: cls = C_ST;
      OP_BR: cls = C_BR;
      OP_JR: cls = C_JR;
      OP_JAL: cls = C_JAL;
      OP_IN: cls = C_IN;
      OP_OUT: cls = C_OUT;
      OP_MFHI: cls = C_MFHI;
      OP_MFLO: cls = C_MFLO;
      OP_HALT: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end
  always_comb begin
    last = 4'd3;
    case (cls)
      C_R, C_IMM, C_LDI: last = 4'd5;
      C_MD, C_BR: last = 4'd6;
      C_UN, C_JAL: last = 4'd4;
      C_LD, C_ST: last = 4'd7;
      C_NOP, C_HALT: last = 4'd2;
      default: last = 4'd3;
    endcase
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle fetch/decode/execute control FSM issuing ALU opcodes and datapath strobes.
// SEQ_SINGLE_STEP_EN adds step_go: each instruction then waits in T0 for a step_go rising edge.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CTRL_W      = CTRL_BITS,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_go,
`endif
  input  logic [31:0]       ir,
  input  logic              mem_ack,
  input  logic              con_ff,
  output logic [4:0]        alu_op,
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        step,
  output logic              halted
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_e state, ns;
  cls_e cls;
  logic [3:0] last;
  logic [4:0] opc_q, opc, op_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CTRL_BITS-1:0] c;
  logic start, again, wait_st, unused_ir;
  assign unused_ir = ^ir[26:0];
`ifdef SEQ_SINGLE_STEP_EN
  logic go_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) go_q <= 1'b0;
    else go_q <= step_go;
  assign start = step_go & ~go_q;
  assign again = 1'b0;
`else
  assign start = run;
  assign again = run;
`endif
  // the opcode is live from ir while leaving T2, then held for the rest of the instruction
  assign opc = (state == S_T2) ? ir[31:27] : opc_q;
  seq_decode u_dec (.opc(opc), .cls(cls), .last(last));
  assign wait_st = state == S_T1 || (state == S_T6 && cls == C_LD) || (state == S_T7 && cls == C_ST);
  always_comb begin
    ns = state;
    cnt_n = '0;
    if (state == S_IDLE) ns = start ? S_T0 : S_IDLE;
    else if (state == S_HALT || state == S_FAULT) ns = state;
    else if (wait_st && !mem_ack) begin
      ns = (cnt == CW'(MEM_TIMEOUT - 1)) ? S_FAULT : state;
      cnt_n = cnt + 1'b1;
    end else if (state == state_e'(last)) ns = (cls == C_HALT) ? S_HALT : (again ? S_T0 : S_IDLE);
    else ns = state_e'(state + 4'd1);
  end
  // strobes are decoded from the next state so they register alongside it
  always_comb begin
    c = '0;
    unique case (ns)
      S_T0: c = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
      S_T1: c = M_ZLO | M_PCIN | M_READ | M_MDRIN;
      S_T2: c = M_MDROUT | M_IRIN;
      S_T3:
        unique case (cls)
          C_R, C_IMM: c = M_GRB | M_ROUT | M_YIN;
          C_MD: c = M_GRA | M_ROUT | M_YIN;
          C_UN: c = M_GRB | M_ROUT | M_ZIN;
          C_LD, C_LDI, C_ST: c = M_GRB | M_BAOUT | M_YIN;
          C_BR: c = M_GRA | M_ROUT | M_CONIN;
          C_JR: c = M_GRA | M_ROUT | M_PCIN;
          C_JAL: c = M_PCOUT | M_GRB | M_RIN;
          C_IN: c = M_INPORT | M_GRA | M_RIN;
          C_OUT: c = M_GRA | M_ROUT | M_OUTPORT;
          C_MFHI: c = M_HIOUT | M_GRA | M_RIN;
          C_MFLO: c = M_LOOUT | M_GRA | M_RIN;
          default: c = '0;
        endcase
      S_T4:
        unique case (cls)
          C_R: c = M_GRC | M_ROUT | M_ZIN;
          C_IMM, C_LD, C_LDI, C_ST: c = M_COUT | M_ZIN;
          C_MD: c = M_GRB | M_ROUT | M_ZIN;
          C_UN: c = M_ZLO | M_GRA | M_RIN;
          C_BR: c = M_PCOUT | M_YIN;
          C_JAL: c = M_GRA | M_ROUT | M_PCIN;
          default: c = '0;
        endcase
      S_T5:
        unique case (cls)
          C_R, C_IMM, C_LDI: c = M_ZLO | M_GRA | M_RIN;
          C_MD: c = M_ZLO | M_LOIN;
          C_LD, C_ST: c = M_ZLO | M_MARIN;
          C_BR: c = M_COUT | M_ZIN | M_BRF;
          default: c = '0;
        endcase
      S_T6:
        unique case (cls)
          C_MD: c = M_ZHI | M_HIIN;
          C_LD: c = M_READ | M_MDRIN;
          C_ST: c = M_GRA | M_ROUT | M_MDRIN;
          C_BR: c = con_ff ? (M_ZLO | M_PCIN) : '0;
          default: c = '0;
        endcase
      S_T7: c = (cls == C_LD) ? (M_MDROUT | M_GRA | M_RIN) : (cls == C_ST) ? M_WRITE : '0;
      default: c = '0;
    endcase
  end
  assign op_n = ((ns == S_T4 && (cls == C_R || cls == C_IMM || cls == C_MD)) || (ns == S_T3 && cls == C_UN))
                ? opc : OP_ADD;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      opc_q <= OP_NOP;
      ctrl <= '0;
      alu_op <= OP_ADD;
      step <= 4'h0;
      halted <= 1'b0;
    end else begin
      state <= ns;
      cnt <= cnt_n;
      if (state == S_T2) opc_q <= ir[31:27];
      ctrl <= CTRL_W'(c);
      alu_op <= op_n;
      step <= (ns == S_IDLE) ? 4'h0 : 4'(ns);
      halted <= ns == S_HALT || ns == S_FAULT;
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed instruction sequences with hand-computed strobe expectations
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;
  logic clk = 1'b0, reset, run, mem_ack, con_ff;
  logic [31:0] ir;
  logic [4:0] alu_op;
  logic [CTRL_BITS-1:0] ctrl;
  logic [3:0] step;
  logic halted;
  int checks = 0, passed = 0, fails = 0, n = 0;
  logic [CTRL_BITS-1:0] ct[32];
  logic [4:0] op[32];
  logic [3:0] sl[32];
  always #5 clk = ~clk;
  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_ack(mem_ack), .con_ff(con_ff),
    .alu_op(alu_op), .ctrl(ctrl), .step(step), .halted(halted)
  );
  function automatic logic [CTRL_BITS-1:0] b(input int i);
    b = '0;
    b[i] = 1'b1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // runs one instruction from idle; ack is withheld for ack_delay cycles of step ack_step
  task automatic run_instr(input logic [31:0] i, input logic [3:0] ack_step, input int ack_delay);
    int k = 0;
    ir = i;
    run = 1'b1;
    mem_ack = 1'b1;
    tick();
    run = 1'b0;
    n = 0;
    while (n < 400 && !(step == 4'h0 && ctrl == '0) && !halted) begin
      if (n < 32) begin
        ct[n] = ctrl;
        op[n] = alu_op;
        sl[n] = step;
      end
      mem_ack = (step != ack_step) || (k >= ack_delay);
      k = (step == ack_step) ? k + 1 : 0;
      n++;
      tick();
    end
    mem_ack = 1'b1;
  endtask
  initial begin
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; con_ff = 1'b0; ir = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_aluop", 32'(alu_op), 32'h3);
    chk("rst_halted", 32'(halted), 32'h0);
    tick();
    chk("idle_no_run", 32'(ctrl), 32'h0);
    run_instr(32'h1891_8000, 4'd0, 0);
    chk("add_cycles", n, 6);
    chk("add_t0", 32'(ct[0]), 32'(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN)));
    chk("add_t1", 32'(ct[1]), 32'(b(ZLO_OUT) | b(PCIN) | b(READ) | b(MDRIN)));
    chk("add_t2", 32'(ct[2]), 32'(b(MDROUT) | b(IRIN)));
    chk("add_t3", 32'(ct[3]), 32'(b(GRB) | b(ROUT) | b(YIN)));
    chk("add_t4", 32'(ct[4]), 32'(b(GRC) | b(ROUT) | b(ZIN)));
    chk("add_t4_op", 32'(op[4]), 32'h03);
    chk("add_t5", 32'(ct[5]), 32'(b(ZLO_OUT) | b(GRA) | b(RIN)));
    chk("add_t5_step", 32'(sl[5]), 32'h5);
    run_instr({5'b00000, 4'd2, 4'd3, 19'h10}, 4'd6, 3);
    chk("ld_cycles", n, 11);
    chk("ld_t4", 32'(ct[4]), 32'(b(COUT) | b(ZIN)));
    chk("ld_t5", 32'(ct[5]), 32'(b(ZLO_OUT) | b(MARIN)));
    chk("ld_t6_first", 32'(ct[6]), 32'(b(READ) | b(MDRIN)));
    chk("ld_t6_held", 32'(ct[9]), 32'(b(READ) | b(MDRIN)));
    chk("ld_t6_held_step", 32'(sl[9]), 32'h6);
    chk("ld_t7", 32'(ct[10]), 32'(b(MDROUT) | b(GRA) | b(RIN)));
    chk("ld_t7_step", 32'(sl[10]), 32'h7);
    con_ff = 1'b0;
    run_instr({5'b10011, 4'd1, 4'd0, 19'd0}, 4'd0, 0);
    chk("br0_cycles", n, 7);
    chk("br0_t3", 32'(ct[3]), 32'(b(GRA) | b(ROUT) | b(CONIN)));
    chk("br0_t4", 32'(ct[4]), 32'(b(PCOUT) | b(YIN)));
    chk("br0_t5", 32'(ct[5]), 32'(b(COUT) | b(ZIN) | b(BRANCH_FLAG)));
    chk("br0_t6", 32'(ct[6]), 32'h0);
    chk("br0_t6_step", 32'(sl[6]), 32'h6);
    con_ff = 1'b1;
    run_instr({5'b10011, 4'd1, 4'd0, 19'd0}, 4'd0, 0);
    chk("br1_cycles", n, 7);
    chk("br1_t6", 32'(ct[6]), 32'(b(ZLO_OUT) | b(PCIN)));
    con_ff = 1'b0;
    run_instr({5'b01111, 4'd4, 4'd5, 19'd0}, 4'd0, 0);
    chk("mul_cycles", n, 7);
    chk("mul_t3", 32'(ct[3]), 32'(b(GRA) | b(ROUT) | b(YIN)));
    chk("mul_t4", 32'(ct[4]), 32'(b(GRB) | b(ROUT) | b(ZIN)));
    chk("mul_t4_op", 32'(op[4]), 32'h0F);
    chk("mul_t5", 32'(ct[5]), 32'(b(ZLO_OUT) | b(LOIN)));
    chk("mul_t6", 32'(ct[6]), 32'(b(ZHI_OUT) | b(HIIN)));
    run_instr({5'b10101, 4'd6, 4'd7, 19'd0}, 4'd0, 0);
    chk("jal_cycles", n, 5);
    chk("jal_t3", 32'(ct[3]), 32'(b(PCOUT) | b(GRB) | b(RIN)));
    chk("jal_t4", 32'(ct[4]), 32'(b(GRA) | b(ROUT) | b(PCIN)));
    run_instr(32'h1891_8000, 4'd1, 100000);
    chk("fault_cycles", n, 256);
    chk("fault_step", 32'(step), 32'hE);
    chk("fault_halted", 32'(halted), 32'h1);
    chk("fault_ctrl", 32'(ctrl), 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("fault_rst_step", 32'(step), 32'h0);
    chk("fault_rst_halted", 32'(halted), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    ir = {5'b10000, 4'd6, 4'd7, 19'd0};
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int g = 0; g < 20 && step != 4'h4; g++) tick();
    chk("div_reach_t4", 32'(step), 32'h4);
    chk("div_t4", 32'(ctrl), 32'(b(GRB) | b(ROUT) | b(ZIN)));
    chk("div_t4_op", 32'(alu_op), 32'h10);
    #2 reset = 1'b1;
    #1;
    chk("div_rst_ctrl", 32'(ctrl), 32'h0);
    chk("div_rst_step", 32'(step), 32'h0);
    chk("div_rst_op", 32'(alu_op), 32'h03);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("div_after_rst", 32'({step, ctrl}), 32'h0);
    run_instr({5'b11011, 27'd0}, 4'd0, 0);
    chk("halt_cycles", n, 3);
    chk("halt_step", 32'(step), 32'hF);
    chk("halt_halted", 32'(halted), 32'h1);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", 32'({halted, step, ctrl}), 32'({1'b1, 4'hF, 28'h0}));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
